// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: fetch port vs. program-loader port onto one single-port sync RAM (loader only with IMEM_LOADER_EN).
// Latency: grant is combinational, response/done one cycle after grant; memory read data returned one cycle later.
// Backpressure: requests are held until granted; with both requesting, 1-bit round-robin picks the one not granted last.
module imem_arbiter #(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int mem_depth  = 512,
    localparam int idx_w     = $clog2(mem_depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [addr_width-1:0] fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_rvalid,
    output logic [data_width-1:0] fetch_rdata,
    output logic                  fetch_err,
    input  logic                  load_req,
    input  logic [addr_width-1:0] load_addr,
    input  logic [data_width-1:0] load_wdata,
    output logic                  load_gnt,
    output logic                  load_done,
    output logic                  load_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [idx_w-1:0]      mem_addr,
    output logic [data_width-1:0] mem_wdata,
    input  logic [data_width-1:0] mem_rdata
);

    localparam logic [data_width-1:0] nop_instr = data_width'(32'h0000_0013);

    function automatic logic addr_legal(input logic [addr_width-1:0] a);
        return (a[1:0] == 2'b00) && ((a >> (idx_w + 2)) == '0);
    endfunction

    logic                  fetch_legal;
    logic [data_width-1:0] rdata_hold;

    assign fetch_legal = addr_legal(fetch_addr);

`ifdef IMEM_LOADER_EN
    logic load_legal;
    logic last_load;

    assign load_legal = addr_legal(load_addr);

    always_comb begin
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        if (!rst) begin
            if (fetch_req && load_req) begin
                fetch_gnt = last_load;
                load_gnt  = !last_load;
            end else begin
                fetch_gnt = fetch_req;
                load_gnt  = load_req;
            end
        end
    end

    // Pointer resets to "load last" so fetch wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_load <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            if (fetch_gnt || load_gnt)
                last_load <= load_gnt;
            load_done <= load_gnt;
            load_err  <= load_gnt && !load_legal;
        end
    end
`else
    logic unused_load;

    assign fetch_gnt   = fetch_req && !rst;
    assign load_gnt    = 1'b0;
    assign load_done   = 1'b0;
    assign load_err    = 1'b0;
    assign unused_load = ^{load_req, load_addr, load_wdata};
`endif

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = fetch_addr[idx_w+1:2];
        mem_wdata = '0;
        if (fetch_gnt && fetch_legal)
            mem_en = 1'b1;
`ifdef IMEM_LOADER_EN
        mem_wdata = load_wdata;
        if (load_gnt) begin
            mem_addr = load_addr[idx_w+1:2];
            if (load_legal) begin
                mem_en = 1'b1;
                mem_we = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_rvalid <= 1'b0;
            fetch_err    <= 1'b0;
        end else begin
            fetch_rvalid <= fetch_gnt;
            fetch_err    <= fetch_gnt && !fetch_legal;
        end
    end

    // Legal responses pass RAM data straight through; the hold register
    // keeps the last returned word and pre-loads the NOP for error responses.
    always_ff @(posedge clk) begin
        if (rst)
            rdata_hold <= '0;
        else if (fetch_gnt && !fetch_legal)
            rdata_hold <= nop_instr;
        else if (fetch_rvalid && !fetch_err)
            rdata_hold <= mem_rdata;
    end

    assign fetch_rdata = (fetch_rvalid && !fetch_err) ? mem_rdata : rdata_hold;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios then random traffic against a word-array reference model.
// Works in both builds; the loader expectations follow IMEM_LOADER_EN.
module tb_imem_arbiter;

`ifdef IMEM_LOADER_EN
    localparam bit loader_en = 1'b1;
`else
    localparam bit loader_en = 1'b0;
`endif
    localparam int depth = 512;
    localparam logic [31:0] nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_gnt, fetch_rvalid, fetch_err;
    logic [31:0] fetch_rdata;
    logic        load_req = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_wdata = '0;
    logic        load_gnt, load_done, load_err;
    logic        mem_en, mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] phys[depth];
    logic [31:0] ref_mem[depth];
    logic        init_mem = 1'b0;

    bit          m_last_load = 1'b1;
    logic [31:0] m_rdata = '0;

    imem_arbiter dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
        .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata),
        .load_gnt(load_gnt), .load_done(load_done), .load_err(load_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one-cycle synchronous read.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < depth; i++) phys[i] <= ref_mem[i];
        end else if (mem_en) begin
            if (mem_we) phys[mem_addr] <= mem_wdata;
            else        mem_rdata <= phys[mem_addr];
        end
    end

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < 4 * depth);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit fr, input logic [31:0] fa,
                        input bit lr, input logic [31:0] la, input logic [31:0] lw);
        bit eg_f, eg_l, f_ok, l_ok;
        bit e_rv, e_fe, e_ld, e_le;
        @(negedge clk);
        rst = r; fetch_req = fr; fetch_addr = fa;
        load_req = lr; load_addr = la; load_wdata = lw;
        #1;
        eg_f = 1'b0;
        eg_l = 1'b0;
        if (!r) begin
            if (!loader_en)        eg_f = fr;
            else if (fr && lr)     begin eg_f = m_last_load; eg_l = !m_last_load; end
            else                   begin eg_f = fr; eg_l = lr; end
        end
        f_ok = legal(fa);
        l_ok = legal(la);
        chk("fetch_gnt", fetch_gnt, eg_f);
        chk("load_gnt", load_gnt, eg_l);
        chk("mem_en", mem_en, (eg_f && f_ok) || (eg_l && l_ok));
        chk("mem_we", mem_we, eg_l && l_ok);
        if (eg_f && f_ok) chk("mem_addr_fetch", mem_addr, fa / 4);
        if (eg_l && l_ok) begin
            chk("mem_addr_load", mem_addr, la / 4);
            chk("mem_wdata", mem_wdata, lw);
        end
        e_rv = eg_f;
        e_fe = eg_f && !f_ok;
        e_ld = eg_l;
        e_le = eg_l && !l_ok;
        if (r) begin
            m_rdata = '0;
            m_last_load = 1'b1;
        end else begin
            if (eg_f) m_rdata = f_ok ? ref_mem[fa / 4] : nop;
            if (eg_l && l_ok) ref_mem[la / 4] = lw;
            if (eg_f || eg_l) m_last_load = eg_l;
        end
        @(posedge clk);
        #1;
        chk("fetch_rvalid", fetch_rvalid, e_rv);
        chk("fetch_err", fetch_err, e_fe);
        chk("fetch_rdata", fetch_rdata, m_rdata);
        chk("load_done", load_done, e_ld);
        chk("load_err", load_err, e_le);
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 7)       return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        else if (sel == 7) return {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
        else if (sel == 8) return 32'h800 | {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
        else               return $urandom;
    endfunction

    initial begin
        for (int i = 0; i < depth; i++) ref_mem[i] = $urandom;
        ref_mem[2] = 32'h0050_0093;
        init_mem = 1'b1;
        @(posedge clk);
        #1;
        init_mem = 1'b0;

        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 32'h8, 1, 32'h10, 32'h1);
        chk("reset_rdata_zero", fetch_rdata, 32'h0);

        step(0, 1, 32'h8, 0, 0, 0);
        chk("first_fetch_word", fetch_rdata, 32'h0050_0093);

        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 32'h44, 1, 32'h40, $urandom);

        step(0, 1, 32'h6, 0, 0, 0);
        step(0, 1, 32'h800, 0, 0, 0);

        step(0, 0, 0, 1, 32'h10, 32'hDEAD_BEEF);
        step(0, 1, 32'h10, 0, 0, 0);

        step(0, 1, 32'h8, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) != 0, rand_addr(),
                 $urandom_range(0, 3) != 0, rand_addr(), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
